sync_fifo_thresh: RTL and testbench
===================================

SYNC_FIFO_THRESH -- requirements
Module: sync_fifo_thresh

Interface
REQ-001 Parameter BITWIDTH, default 5: data word width in bits.
REQ-002 Parameter DEPTH, default 4: address bits; capacity = 2**DEPTH entries.
REQ-003 Parameter AF_LEVEL, default 14: almostFull threshold, legal range 1..2**DEPTH.
REQ-004 Parameter AE_LEVEL, default 2: almostEmpty threshold, legal range 0..2**DEPTH-1.
REQ-005 clk  input  1  sole clock, all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 wEn  input  1  push request.
REQ-008 dIn  input  BITWIDTH  push data.
REQ-009 rEn  input  1  pop request; head data is always visible on dOut, so rEn means pop, not read.
REQ-010 flush  input  1  synchronous discard of all contents.
REQ-011 dOut  output  BITWIDTH  head entry (show-ahead).
REQ-012 full, empty  output  1 each  occupancy == 2**DEPTH / == 0.
REQ-013 almostFull, almostEmpty  output  1 each  count >= AF_LEVEL / count <= AE_LEVEL.
REQ-014 count  output  DEPTH+1  current occupancy.
REQ-015 overflow, underflow, errClr  output, output, input  1 each  sticky error flags and their clear (present only with FIFO_ERR_FLAGS_EN).

Function
REQ-016 Push accepted iff wEn && (!full || rEn); pop accepted iff rEn && (!empty || wEn).
REQ-017 Accepted push writes dIn at the write pointer; the write pointer increments modulo 2**DEPTH.
REQ-018 Accepted pop advances the read pointer modulo 2**DEPTH.
REQ-019 count: +1 push only, -1 pop only, unchanged on both or neither; count never exceeds 2**DEPTH and never drops below 0.
REQ-020 dOut: storage[rdPtr] when !empty; dIn when empty && wEn (combinational bypass); 0 when empty && !wEn.
REQ-021 Empty && wEn && rEn: data passes dIn->dOut in the same cycle; count stays 0 and empty stays 1.
REQ-022 Full && wEn && rEn: head is popped and dIn is written in the same edge; count stays 2**DEPTH.
REQ-023 Word pushed at edge N appears on dOut after edge N if it is the head; no extra latency.
REQ-024 full, empty, almostFull, almostEmpty decode from the registered count only; they update on the same edge as count.
REQ-025 flush=1 at an edge: pointers and count go to 0 and wEn/rEn are ignored that cycle; storage contents need not be cleared.
REQ-026 Pointer wrap-around from 2**DEPTH-1 to 0 shall not disturb data order.

Reset
REQ-027 rst=1 at an edge has priority over flush, wEn, rEn and errClr.
REQ-028 Reset values: count=0, pointers=0, empty=1, full=0, almostEmpty=1, almostFull=0, overflow=0, underflow=0, dOut=0 (absent wEn).
REQ-029 Reset mid-burst discards all contents; the first push after rst deasserts lands at storage[0].

Configuration
REQ-030 Macro FIFO_ERR_FLAGS_EN defined: overflow sets on wEn && full && !rEn; underflow sets on rEn && empty && !wEn; both hold until errClr=1 or rst; flush does not clear them.
REQ-031 Macro FIFO_ERR_FLAGS_EN undefined: overflow, underflow and errClr ports do not exist; rejected requests are silently dropped; all other behaviour is identical.

Structure
REQ-032 Package sync_fifo_pkg holds a clog2 function and default constants for BITWIDTH, DEPTH, AF_LEVEL and AE_LEVEL.
REQ-033 Sub-module fifo_mem_2p is a 2**DEPTH x BITWIDTH array with one synchronous write port and one asynchronous read port; it has no reset.
REQ-034 Pointers, count, flags and the bypass mux stay in sync_fifo_thresh.

Verification
REQ-035 Push 16 words 0..15 with no pops -> full=1, count=16, almostFull asserted at count=14; 17th push with rEn=0 is dropped and overflow=1.
REQ-036 Full FIFO, wEn=rEn=1 with dIn=16 -> dOut shows 0 before the edge, 1 after; count stays 16; word 16 is read out last.
REQ-037 Empty FIFO, wEn=rEn=1 with dIn=7 -> dOut=7 in the same cycle; empty stays 1, count stays 0.
REQ-038 Random bursts of 500 reads, mixed push/pop lengths -> dOut equals an incrementing reference mod 32 on every pop; zero mismatches; pointers wrap at least 30 times.
REQ-039 count=9, flush=1 with wEn=1 -> after the edge count=0, empty=1, dOut=0; overflow/underflow unchanged.
REQ-040 rst asserted for 1 cycle at count=5 -> all outputs at reset values; a subsequent push of 3 gives dOut=3.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared defaults and helper function for the show-ahead threshold FIFO.
// Imported by fifo_mem_2p and sync_fifo_thresh.
package sync_fifo_pkg;

  localparam int DEF_BITWIDTH = 5;
  localparam int DEF_DEPTH    = 4;
  localparam int DEF_AF_LEVEL = 14;
  localparam int DEF_AE_LEVEL = 2;

  // Smallest n such that 2**n >= value; used to size addresses from a word count.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// Simple two-port storage array: one synchronous write port, one asynchronous read port.
// Holds no reset; the FIFO controller decides which entries are valid.
module fifo_mem_2p
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_BITWIDTH,
  parameter int WORDS = 2 ** DEF_DEPTH,
  parameter int AW    = clog2(WORDS)
) (
  input  logic             clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [WORDS];

  // NOTE: storage is deliberately left without reset so it maps onto plain RAM;
  // validity of each entry is tracked by the pointers and count in the controller.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/sync_fifo_thresh.sv
// Show-ahead synchronous FIFO with almost-full/almost-empty thresholds and empty bypass.
// Optional sticky overflow/underflow flags are built when FIFO_ERR_FLAGS_EN is defined.
module sync_fifo_thresh
  import sync_fifo_pkg::*;
#(
  parameter int BITWIDTH = DEF_BITWIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEF_AF_LEVEL,
  parameter int AE_LEVEL = DEF_AE_LEVEL
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wEn,
  input  logic [BITWIDTH-1:0] dIn,
  input  logic                rEn,
  input  logic                flush,
  output logic [BITWIDTH-1:0] dOut,
  output logic                full,
  output logic                empty,
  output logic                almostFull,
  output logic                almostEmpty,
  output logic [DEPTH:0]      count
`ifdef FIFO_ERR_FLAGS_EN
  ,
  input  logic                errClr,
  output logic                overflow,
  output logic                underflow
`endif
);

  localparam int             LP_CAP     = 1 << DEPTH;
  localparam logic [DEPTH:0] LP_CAP_CNT = LP_CAP[DEPTH:0];
  localparam logic [DEPTH:0] LP_AF_CNT  = AF_LEVEL[DEPTH:0];
  localparam logic [DEPTH:0] LP_AE_CNT  = AE_LEVEL[DEPTH:0];

  logic [DEPTH-1:0]    r_wr_ptr;
  logic [DEPTH-1:0]    r_rd_ptr;
  logic [DEPTH:0]      r_count;

  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic                w_mem_wr_en;
  logic [BITWIDTH-1:0] w_mem_rd_data;

  // Status decodes come only from the registered count.
  assign w_full  = (r_count == LP_CAP_CNT);
  assign w_empty = (r_count == '0);

  // A pop frees a slot for a simultaneous push, and a push can feed a simultaneous
  // pop through the bypass, so each side is allowed when the other is requested.
  assign w_push      = wEn && (!w_full  || rEn);
  assign w_pop       = rEn && (!w_empty || wEn);
  assign w_mem_wr_en = w_push && !flush && !rst;

  fifo_mem_2p #(
    .WIDTH (BITWIDTH),
    .WORDS (LP_CAP)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (w_mem_wr_en),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (dIn),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_mem_rd_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + DEPTH'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + DEPTH'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (DEPTH+1)'(1);
        2'b01:   r_count <= r_count - (DEPTH+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: dOut is given a default before the branches so no latch is inferred.
  always_comb begin
    dOut = '0;
    if (!w_empty)  dOut = w_mem_rd_data;
    else if (wEn)  dOut = dIn;
  end

  assign full        = w_full;
  assign empty       = w_empty;
  assign almostFull  = (r_count >= LP_AF_CNT);
  assign almostEmpty = (r_count <= LP_AE_CNT);
  assign count       = r_count;

`ifdef FIFO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  // Sticky until errClr or rst; a flush ignores requests, so it neither sets nor clears them.
  always_ff @(posedge clk) begin
    if (rst || errClr) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (!flush) begin
      if (wEn && w_full && !rEn)  r_overflow  <= 1'b1;
      if (rEn && w_empty && !wEn) r_underflow <= 1'b1;
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif

endmodule

// File: tb/tb_sync_fifo_thresh.sv
// Self-checking bench for sync_fifo_thresh: a queue model predicts every popped word and
// the occupancy flags; the sticky error flags are checked when FIFO_ERR_FLAGS_EN is defined.
module tb_sync_fifo_thresh;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wEn = 1'b0;
  logic [4:0] dIn = '0;
  logic       rEn = 1'b0;
  logic       flush = 1'b0;
  logic [4:0] dOut;
  logic       full, empty, almostFull, almostEmpty;
  logic [4:0] count;
`ifdef FIFO_ERR_FLAGS_EN
  logic       errClr = 1'b0;
  logic       overflow, underflow;
`endif

  sync_fifo_thresh #(
    .BITWIDTH (5),
    .DEPTH    (4),
    .AF_LEVEL (14),
    .AE_LEVEL (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wEn         (wEn),
    .dIn         (dIn),
    .rEn         (rEn),
    .flush       (flush),
    .dOut        (dOut),
    .full        (full),
    .empty       (empty),
    .almostFull  (almostFull),
    .almostEmpty (almostEmpty),
    .count       (count)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .errClr      (errClr),
    .overflow    (overflow),
    .underflow   (underflow)
`endif
  );

  always #5 clk = ~clk;

  int         n_vec  = 0;
  int         n_err  = 0;
  int         n_pops = 0;
  int         m_rd   = 0;
  int         m_wraps = 0;
  bit         m_ovf  = 1'b0;
  bit         m_udf  = 1'b0;
  bit         last_push;
  logic [4:0] q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_state();
    logic [4:0] exp_out;
    exp_out = (q.size() != 0) ? q[0] : (wEn ? dIn : 5'd0);
    check("count",       count,       q.size());
    check("full",        full,        q.size() == 16);
    check("empty",       empty,       q.size() == 0);
    check("almostFull",  almostFull,  q.size() >= 14);
    check("almostEmpty", almostEmpty, q.size() <= 2);
    check("dOut_idle",   dOut,        exp_out);
`ifdef FIFO_ERR_FLAGS_EN
    check("overflow",    overflow,    m_ovf);
    check("underflow",   underflow,   m_udf);
`endif
  endtask

  // One clock: drive inputs, verify any pop before the edge, update the model, verify after.
  task automatic step(input bit we, input logic [4:0] din, input bit re,
                      input bit fl, input bit rs, input bit ec);
    bit m_full, m_empty, push, pop;
    logic [4:0] exp;
    wEn = we; dIn = din; rEn = re; flush = fl; rst = rs;
`ifdef FIFO_ERR_FLAGS_EN
    errClr = ec;
`endif
    @(negedge clk);
    m_empty = (q.size() == 0);
    m_full  = (q.size() == 16);
    push = we && (!m_full || re);
    pop  = re && (!m_empty || we);
    last_push = push && !fl && !rs;
    if (!rs && !fl && pop) begin
      exp = m_empty ? din : q[0];
      check("pop_data", dOut, exp);
      n_pops++;
    end
    @(posedge clk);
    #1;
    if (rs || fl) begin
      q.delete();
      m_rd = 0;
    end else begin
      if (pop) begin
        if (!m_empty) void'(q.pop_front());
        m_rd = (m_rd + 1) % 16;
        if (m_rd == 0) m_wraps++;
      end
      if (push && !(m_empty && pop)) q.push_back(din);
    end
    if (rs || ec) begin
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else if (!fl) begin
      if (we && m_full && !re)  m_ovf = 1'b1;
      if (re && m_empty && !we) m_udf = 1'b1;
    end
    check_state();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base_pops, base_wraps, budget, next_val;

    // Reset state
    step(0, 5'd0, 0, 0, 1, 0);
    step(0, 5'd0, 0, 0, 1, 0);

    // Fill with 0..15, then a rejected 17th push
    for (int i = 0; i < 16; i++) step(1, 5'(i), 0, 0, 0, 0);
    step(1, 5'd31, 0, 0, 0, 0);

    // Full with simultaneous push/pop, then drain; 16 comes out last
    step(1, 5'd16, 1, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 5'd0, 1, 0, 0, 0);
    step(0, 5'd0, 1, 0, 0, 0);

    // Empty pass-through
    step(1, 5'd7, 1, 0, 0, 0);

    // Flush at count 9 with wEn held, then idle
    for (int i = 0; i < 9; i++) step(1, 5'(i + 1), 0, 0, 0, 0);
    step(1, 5'd20, 0, 1, 0, 0);
    step(0, 5'd0, 0, 0, 0, 0);
    step(0, 5'd0, 0, 0, 0, 1);

    // Reset mid-content at count 5, then push 3
    for (int i = 0; i < 5; i++) step(1, 5'(i + 10), 0, 0, 0, 0);
    step(0, 5'd0, 0, 0, 1, 0);
    step(1, 5'd3, 0, 0, 0, 0);
    step(0, 5'd0, 1, 0, 0, 0);

    // Random push/pop bursts carrying an incrementing sequence
    base_pops  = n_pops;
    base_wraps = m_wraps;
    budget     = 0;
    next_val   = 0;
    while ((n_pops - base_pops) < 500 && budget < 20000) begin
      int len;
      bit mode;
      len  = $urandom_range(1, 20);
      mode = 1'($urandom_range(0, 1));
      for (int k = 0; k < len; k++) begin
        bit we, re;
        if (mode) begin
          we = 1'b1;
          re = ($urandom_range(0, 3) == 0);
        end else begin
          re = 1'b1;
          we = ($urandom_range(0, 3) == 0);
        end
        step(we, 5'(next_val), re, 0, 0, 0);
        if (last_push) next_val++;
        budget++;
      end
    end
    check("rand_pops_done", 32'((n_pops - base_pops) >= 500), 32'd1);
    check("ptr_wraps",      32'((m_wraps - base_wraps) >= 30), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
